tdc_capture_readout: RTL and testbench

TDC_CAPTURE_READOUT -- requirements
Module: tdc_capture_readout

---
 rtl/tdc_capture_readout.sv | 88 ++++++++
 tb/tb_tdc_capture_readout.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_capture_readout.sv
// tdc_capture_readout: averages thermometer-coded TDC snapshots and reads out mean/min/max/status bytes
module tdc_capture_readout #(
  parameter int TAPS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [TAPS-1:0] tap_in,
  input  logic            tap_valid,
  input  logic            start,
  input  logic [1:0]      avg_sel,
  input  logic            rd_next,
  output logic [7:0]      data_out,
  output logic            data_valid,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, ACQ, CALC, READ} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_sel, r_idx;
  logic [11:0] r_sum;
  logic [6:0]  r_cnt, w_n;
  logic [5:0]  r_min, r_max, r_mean, w_code;
  logic        r_sat, r_nohit, w_clear, w_take, w_last;
  assign w_n     = 7'd1 << {r_sel, 1'b0};
  assign w_clear = ena && start && (r_state == IDLE || r_state == READ);
  assign w_take  = r_state == ACQ && tap_valid;
  assign w_last  = w_take && (r_cnt + 7'd1 == w_n);
  // popcount of the snapshot; counting ones makes bubbles harmless
  always_comb begin
    w_code = '0;
    for (int i = 0; i < TAPS; i++) w_code = w_code + {5'd0, tap_in[i]};
  end
  // next-state decode; a dropped enable always wins
  always_comb begin
    w_next = r_state;
    if (!ena) w_next = IDLE;
    else
      case (r_state)
        IDLE:    w_next = start ? ACQ : IDLE;
        ACQ:     w_next = w_last ? CALC : ACQ;
        CALC:    w_next = READ;
        default: w_next = start ? ACQ : (rd_next && r_idx == 2'd3) ? IDLE : READ;
      endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // accumulator, extrema, sticky flags, mean and readout index
  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      r_sel   <= rst_n ? avg_sel : 2'd0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_min   <= 6'd63;
      r_max   <= '0;
      r_sat   <= 1'b0;
      r_nohit <= 1'b0;
      r_idx   <= '0;
      r_mean  <= rst_n ? r_mean : 6'd0;
    end else if (ena) begin
      if (w_take) begin
        r_sum   <= r_sum + {6'd0, w_code};
        r_cnt   <= r_cnt + 7'd1;
        r_min   <= (w_code < r_min) ? w_code : r_min;
        r_max   <= (w_code > r_max) ? w_code : r_max;
        r_sat   <= r_sat | (w_code == 6'd32);
        r_nohit <= r_nohit | (w_code == 6'd0);
      end
      if (r_state == CALC) begin
        r_mean <= 6'(r_sum >> {r_sel, 1'b0});
        r_idx  <= '0;
      end
      if (r_state == READ && rd_next) r_idx <= r_idx + 2'd1;
    end
  end
  // outputs are silenced while reset is asserted
  always_comb begin
    data_valid = rst_n && r_state == READ;
    busy       = rst_n && (r_state == ACQ || r_state == CALC);
    data_out   = !data_valid   ? 8'h00 :
                 r_idx == 2'd0 ? {2'b00, r_mean} :
                 r_idx == 2'd1 ? {2'b00, r_min} :
                 r_idx == 2'd2 ? {2'b00, r_max} :
                                 {r_sat, r_nohit, r_sel, 4'b0000};
  end
endmodule

// File: tb/tb_tdc_capture_readout.sv
// tb_tdc_capture_readout: directed self-checking bench for the TDC capture/readout tile
module tb_tdc_capture_readout;
  logic        clk = 0, rst_n = 0, ena = 1, tap_valid = 0, start = 0, rd_next = 0;
  logic [31:0] tap_in = '0;
  logic [1:0]  avg_sel = '0;
  logic [7:0]  data_out;
  logic        data_valid, busy;
  int          n_chk = 0, n_fail = 0;

  tdc_capture_readout #(.TAPS(32)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tap_in(tap_in), .tap_valid(tap_valid),
    .start(start), .avg_sel(avg_sel), .rd_next(rd_next),
    .data_out(data_out), .data_valid(data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] therm(input int c);
    logic [63:0] m;
    m = (64'd1 << c) - 64'd1;
    return m[31:0];
  endfunction

  task automatic go(input logic [1:0] s);
    avg_sel = s;
    start = 1;
    tick();
    start = 0;
    avg_sel = s + 2'd1;
  endtask

  task automatic sample(input logic [31:0] v);
    tap_in = v;
    tap_valid = 1;
    tick();
    tap_valid = 0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (data_valid === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic read4(output logic [31:0] b);
    b = '0;
    for (int i = 0; i < 4; i++) begin
      b = {b[23:0], data_out};
      rd_next = 1;
      tick();
      rd_next = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    n_chk++; if ({data_out, data_valid, busy} !== 10'd0) begin n_fail++; $display("FAIL reset_async_view: got out=%h dv=%b busy=%b want 0", data_out, data_valid, busy); end
    tick(); tick();
    n_chk++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    n_chk++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1;
    tick();
    n_chk++; if ({data_out, data_valid, busy} !== 10'd0) begin n_fail++; $display("FAIL reset_release: got out=%h dv=%b busy=%b want 0", data_out, data_valid, busy); end
  endtask

  task automatic test_single();
    logic [31:0] b;
    int nb;
    go(2'd0);
    nb = busy ? 1 : 0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_acq: got %b want 1", busy); end
    sample(32'h0000_FFFF);
    nb += busy ? 1 : 0;
    n_chk++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL single_dv_calc: got %b want 0", data_valid); end
    tick();
    nb += busy ? 1 : 0;
    n_chk++; if (nb !== 2) begin n_fail++; $display("FAIL single_busy_cycles: got %0d want 2", nb); end
    n_chk++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL single_dv_read: got %b want 1", data_valid); end
    read4(b);
    n_chk++; if (b !== 32'h1010_1000) begin n_fail++; $display("FAIL single_bytes: got %h want 10101000", b); end
    n_chk++; if (data_valid !== 1'b0 || data_out !== 8'h00) begin n_fail++; $display("FAIL single_after_read: got dv=%b out=%h want 0/00", data_valid, data_out); end
  endtask

  task automatic test_gapped();
    logic [31:0] b;
    bit ok;
    int codes[4] = '{8, 9, 10, 12};
    tap_in = 32'h0;
    tap_valid = 1;
    tick(); tick();
    tap_valid = 0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gapped_idle_ignores_valid: got busy=%b want 0", busy); end
    go(2'd1);
    foreach (codes[i]) begin
      sample(therm(codes[i]));
      tap_in = 32'hFFFF_FFFF;
      if (i < 3) begin
        tick();
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gapped_busy_%0d: got %b want 1", i, busy); end
      end
    end
    wait_valid(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL gapped_timeout: got no data_valid want 1"); end
    read4(b);
    n_chk++; if (b !== 32'h0908_0C10) begin n_fail++; $display("FAIL gapped_bytes: got %h want 09080C10", b); end
  endtask

  task automatic test_saturate();
    logic [31:0] b;
    bit ok;
    go(2'd3);
    for (int i = 0; i < 63; i++) begin
      start = (i == 10);
      sample(32'hFFFF_FFFF);
      start = 0;
    end
    n_chk++; if (busy !== 1'b1 || data_valid !== 1'b0) begin n_fail++; $display("FAIL sat_after63: got busy=%b dv=%b want 1/0", busy, data_valid); end
    sample(32'hFFFF_FFFF);
    wait_valid(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL sat_timeout: got no data_valid want 1"); end
    read4(b);
    n_chk++; if (b !== 32'h2020_20B0) begin n_fail++; $display("FAIL sat_bytes: got %h want 202020B0", b); end
  endtask

  task automatic test_bubble();
    logic [31:0] b;
    bit ok;
    go(2'd1);
    sample(32'h0000_0F7F);
    sample(32'h0);
    sample(32'h0000_0F7F);
    sample(32'h0000_0F7F);
    wait_valid(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bubble_timeout: got no data_valid want 1"); end
    read4(b);
    n_chk++; if (b !== 32'h0800_0B50) begin n_fail++; $display("FAIL bubble_bytes: got %h want 08000B50", b); end
  endtask

  task automatic test_abort();
    logic [31:0] b;
    bit ok;
    go(2'd0);
    sample(therm(5));
    wait_valid(ok);
    rd_next = 1;
    tick(); tick();
    rd_next = 0;
    n_chk++; if (data_out !== 8'h05) begin n_fail++; $display("FAIL abort_idx2: got %h want 05", data_out); end
    avg_sel = 2'd0;
    start = 1;
    rd_next = 1;
    tick();
    start = 0;
    rd_next = 0;
    avg_sel = 2'd2;
    n_chk++; if (busy !== 1'b1 || data_valid !== 1'b0 || data_out !== 8'h00) begin n_fail++; $display("FAIL abort_restart: got busy=%b dv=%b out=%h want 1/0/00", busy, data_valid, data_out); end
    sample(therm(20));
    wait_valid(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL abort_timeout: got no data_valid want 1"); end
    read4(b);
    n_chk++; if (b !== 32'h1414_1400) begin n_fail++; $display("FAIL abort_bytes: got %h want 14141400", b); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] b;
    bit ok;
    go(2'd1);
    sample(therm(7));
    sample(therm(7));
    rst_n = 0;
    tick();
    n_chk++; if ({data_out, data_valid, busy} !== 10'd0) begin n_fail++; $display("FAIL rstmid_low: got out=%h dv=%b busy=%b want 0", data_out, data_valid, busy); end
    rst_n = 1;
    sample(therm(7));
    sample(therm(7));
    n_chk++; if ({data_out, data_valid, busy} !== 10'd0) begin n_fail++; $display("FAIL rstmid_no_partial: got out=%h dv=%b busy=%b want 0", data_out, data_valid, busy); end
    go(2'd0);
    sample(therm(3));
    wait_valid(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: got no data_valid want 1"); end
    read4(b);
    n_chk++; if (b !== 32'h0303_0300) begin n_fail++; $display("FAIL rstmid_bytes: got %h want 03030300", b); end
  endtask

  task automatic test_ena();
    logic [31:0] b;
    bit ok;
    go(2'd1);
    sample(therm(2));
    sample(therm(2));
    ena = 0;
    tick();
    n_chk++; if (busy !== 1'b0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL ena_drop: got busy=%b dv=%b want 0/0", busy, data_valid); end
    start = 1;
    tick();
    start = 0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ena_start_ignored: got busy=%b want 0", busy); end
    ena = 1;
    go(2'd0);
    sample(therm(30));
    wait_valid(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL ena_timeout: got no data_valid want 1"); end
    read4(b);
    n_chk++; if (b !== 32'h1E1E_1E00) begin n_fail++; $display("FAIL ena_bytes: got %h want 1E1E1E00", b); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gapped();
    test_saturate();
    test_bubble();
    test_abort();
    test_reset_mid();
    test_ena();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
